// File: rtl/mem_port_arbiter.sv
// Memory master port arbiter: shares one bus master between the I-cache miss
// path and the D-cache/LSU. One transaction in flight, round-robin on conflict,
// response routed back to its owner; flushed I-side responses are dropped.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  // I-cache side
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_flush,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  // D-cache / LSU side
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_done,
  output logic [DATA_W-1:0]     d_rdata,
  // master port
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_ready,
  input  logic                  m_done,
  input  logic [DATA_W-1:0]     m_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_REQ  = 3'd1,
    I_RESP = 3'd2,
    D_REQ  = 3'd3,
    D_RESP = 3'd4
  } state_t;

  state_t state;
  logic   last_grant_d;   // 1: D side won the most recent grant
  logic   kill;           // in-flight I transaction was flushed
  logic   i_pulse;        // registered I response pulse, before flush gating

  logic   i_elig;
  logic   d_elig;
  logic   grant_d;

  // A flush arriving in the pulse cycle itself still hides the response.
  assign i_rvalid = i_pulse & ~i_flush;

  // Eligibility and round-robin pick; a side whose response pulse is out this
  // cycle is still holding its stale request and must not be re-granted.
  always_comb begin
    i_elig  = i_req & ~i_flush & ~i_pulse;
    d_elig  = d_req & ~d_done;
    grant_d = d_elig & (~i_elig | ~last_grant_d);
  end

  // Arbitration FSM with registered request fields and response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      kill         <= 1'b0;
      i_pulse      <= 1'b0;
      i_rdata      <= '0;
      d_done       <= 1'b0;
      d_rdata      <= '0;
      m_req        <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_wstrb      <= '0;
    end else begin
      i_pulse <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (i_elig || d_elig) begin
            m_req <= 1'b1;
            // last_grant tracks every grant so the loser of a conflict wins next
            if (grant_d) begin
              state        <= D_REQ;
              last_grant_d <= 1'b1;
              m_we         <= d_we;
              m_addr       <= d_addr;
              m_wdata      <= d_wdata;
              m_wstrb      <= d_wstrb;
            end else begin
              state        <= I_REQ;
              last_grant_d <= 1'b0;
              m_we         <= 1'b0;
              m_addr       <= i_addr;
              m_wdata      <= '0;
              m_wstrb      <= '0;
            end
          end
        end
        I_REQ: begin
          // a flushed request is still presented until the bus accepts it
          if (i_flush) kill <= 1'b1;
          if (m_ready) begin
            m_req <= 1'b0;
            state <= I_RESP;
          end
        end
        I_RESP: begin
          if (i_flush) kill <= 1'b1;
          if (m_done) begin
            i_rdata <= m_rdata;
            i_pulse <= ~(kill | i_flush);
            kill    <= 1'b0;
            state   <= IDLE;
          end
        end
        D_REQ: begin
          if (m_ready) begin
            m_req <= 1'b0;
            state <= D_RESP;
          end
        end
        D_RESP: begin
          if (m_done) begin
            d_rdata <= m_rdata;
            d_done  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the basic
// latency and round-robin sequence, then hand sequences for stalls, flushes
// and reset in mid-transaction.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam logic [31:0] IA = 32'h8000_0000;
  localparam logic [31:0] DA = 32'h4000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, i_flush, i_rvalid;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we, d_done;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [7:0]        d_wstrb;
  logic              m_req, m_we, m_ready, m_done;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [7:0]        m_wstrb;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_done(m_done), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_req, i_flush, d_req, m_ready, m_done;
    logic [63:0] rdata;
    logic        e_mreq, e_irv, e_ddone;
    logic [31:0] e_addr;
    logic [63:0] e_data;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic ir, input logic fl, input logic dr,
                              input logic rdy, input logic dn, input logic [63:0] rd,
                              input logic emr, input logic eirv, input logic edd,
                              input logic [31:0] ea, input logic [63:0] ed);
    vec_t v;
    v.i_req = ir; v.i_flush = fl; v.d_req = dr; v.m_ready = rdy; v.m_done = dn;
    v.rdata = rd; v.e_mreq = emr; v.e_irv = eirv; v.e_ddone = edd;
    v.e_addr = ea; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int ndone;
    // row: i_req flush d_req m_ready m_done rdata | m_req i_rvalid d_done m_addr data
    tbl[0]  = mk(1,0,0,1,0,64'h0,    0,0,0,32'h0,64'h0);
    tbl[1]  = mk(1,0,0,1,0,64'h0,    1,0,0,IA,64'h0);
    tbl[2]  = mk(1,0,0,1,0,64'h0,    0,0,0,IA,64'h0);
    tbl[3]  = mk(1,0,0,1,0,64'h0,    0,0,0,IA,64'h0);
    tbl[4]  = mk(1,0,0,1,1,64'hDEAD, 0,0,0,IA,64'h0);
    tbl[5]  = mk(1,0,0,1,0,64'h0,    0,1,0,IA,64'hDEAD);
    tbl[6]  = mk(0,0,0,1,0,64'h0,    0,0,0,IA,64'h0);
    tbl[7]  = mk(0,0,0,1,0,64'h0,    0,0,0,IA,64'h0);
    tbl[8]  = mk(1,0,1,1,0,64'h0,    0,0,0,IA,64'h0);
    tbl[9]  = mk(1,0,1,1,0,64'h0,    1,0,0,DA,64'h0);
    tbl[10] = mk(1,0,1,1,1,64'h1111, 0,0,0,DA,64'h0);
    tbl[11] = mk(1,0,1,1,0,64'h0,    0,0,1,DA,64'h1111);
    tbl[12] = mk(1,0,1,1,0,64'h0,    1,0,0,IA,64'h0);
    tbl[13] = mk(1,0,1,1,1,64'h2222, 0,0,0,IA,64'h0);
    tbl[14] = mk(1,0,1,1,0,64'h0,    0,1,0,IA,64'h2222);
    tbl[15] = mk(0,0,1,1,0,64'h0,    1,0,0,DA,64'h0);
    tbl[16] = mk(0,0,1,1,1,64'h3333, 0,0,0,DA,64'h0);
    tbl[17] = mk(0,0,0,1,0,64'h0,    0,0,1,DA,64'h3333);
    tbl[18] = mk(0,0,0,1,0,64'h0,    0,0,0,DA,64'h0);

    rst = 1'b1; i_req = 0; i_flush = 0; i_addr = IA;
    d_req = 0; d_we = 0; d_addr = DA; d_wdata = '0; d_wstrb = '0;
    m_ready = 0; m_done = 0; m_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst m_req", m_req, 0);
    chk("rst i_rvalid", i_rvalid, 0);
    chk("rst d_done", d_done, 0);
    chk("rst m_addr", m_addr, 0);
    chk("rst m_we", m_we, 0);
    chk("rst m_wstrb", m_wstrb, 0);
    chk("rst i_rdata", i_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    rst = 1'b0;

    // latency, hold-in-pulse-cycle and round-robin sequence
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      i_req = tbl[i].i_req; i_flush = tbl[i].i_flush; d_req = tbl[i].d_req;
      m_ready = tbl[i].m_ready; m_done = tbl[i].m_done; m_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("row%0d m_req", i), m_req, tbl[i].e_mreq);
      chk($sformatf("row%0d i_rvalid", i), i_rvalid, tbl[i].e_irv);
      chk($sformatf("row%0d d_done", i), d_done, tbl[i].e_ddone);
      chk($sformatf("row%0d m_addr", i), m_addr, tbl[i].e_addr);
      if (tbl[i].e_irv) chk($sformatf("row%0d i_rdata", i), i_rdata, tbl[i].e_data);
      if (tbl[i].e_ddone) chk($sformatf("row%0d d_rdata", i), d_rdata, tbl[i].e_data);
    end
    m_ready = 0;

    // D write stalled by m_ready low for 4 cycles; inputs change under it
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h8000_1000; d_wstrb = 8'h0F;
    d_wdata = 64'h0123_4567_89AB_CDEF;
    #1 chk("wr grant m_req", m_req, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) begin d_addr = 32'h0; d_wstrb = 8'hFF; d_wdata = '0; end
      #1;
      chk($sformatf("wr stall%0d m_req", k), m_req, 1);
      chk($sformatf("wr stall%0d m_addr", k), m_addr, 32'h8000_1000);
      chk($sformatf("wr stall%0d m_wstrb", k), m_wstrb, 8'h0F);
      chk($sformatf("wr stall%0d m_we", k), m_we, 1);
      chk($sformatf("wr stall%0d m_wdata", k), m_wdata, 64'h0123_4567_89AB_CDEF);
    end
    @(negedge clk);
    m_ready = 1;
    #1 chk("wr accept m_req", m_req, 1);
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      m_ready = 0;
      m_done = (k == 1);
      #1;
      if (d_done) begin ndone++; d_req = 0; end
    end
    chk("wr d_done count", ndone, 1);
    chk("wr idle m_req", m_req, 0);

    // flush during I_RESP: bus completes, no i_rvalid, waiting D follows
    d_we = 0; d_addr = DA; d_wstrb = '0; d_wdata = '0;
    @(negedge clk); i_req = 1;
    #1 chk("fl grant m_req", m_req, 0);
    @(negedge clk); m_ready = 1; d_req = 1;
    #1;
    chk("fl m_req", m_req, 1);
    chk("fl m_addr", m_addr, IA);
    chk("fl m_we", m_we, 0);
    chk("fl m_wstrb", m_wstrb, 0);
    @(negedge clk); i_flush = 1; i_req = 0; m_ready = 0;
    #1 chk("fl resp m_req", m_req, 0);
    @(negedge clk); i_flush = 0; m_done = 1; m_rdata = 64'hBEEF;
    #1 chk("fl done i_rvalid", i_rvalid, 0);
    @(negedge clk); m_done = 0;
    #1;
    chk("fl pulse i_rvalid", i_rvalid, 0);
    chk("fl idle m_req", m_req, 0);
    @(negedge clk); m_ready = 1;
    #1;
    chk("fl d m_req", m_req, 1);
    chk("fl d m_addr", m_addr, DA);
    chk("fl d i_rvalid", i_rvalid, 0);
    @(negedge clk); m_ready = 0; m_done = 1; m_rdata = 64'h5555;
    #1;
    @(negedge clk); m_done = 0;
    #1;
    chk("fl d_done", d_done, 1);
    chk("fl d_rdata", d_rdata, 64'h5555);
    d_req = 0;

    // flush arriving in the I pulse cycle hides i_rvalid
    @(negedge clk); i_req = 1; m_ready = 1;
    #1 chk("pf grant m_req", m_req, 0);
    @(negedge clk);
    #1 chk("pf m_req", m_req, 1);
    @(negedge clk); m_ready = 0; m_done = 1; m_rdata = 64'hCAFE;
    #1;
    @(negedge clk); m_done = 0; i_flush = 1; i_req = 0;
    #1;
    chk("pf i_rvalid", i_rvalid, 0);
    chk("pf i_rdata", i_rdata, 64'hCAFE);
    @(negedge clk); i_flush = 0;
    #1;
    chk("pf after i_rvalid", i_rvalid, 0);
    chk("pf after m_req", m_req, 0);

    // reset while in D_RESP; later m_done is ignored
    @(negedge clk); d_req = 1; m_ready = 1;
    #1;
    @(negedge clk);
    #1 chk("rs m_req", m_req, 1);
    @(negedge clk); rst = 1; m_ready = 0;
    #1 chk("rs resp m_req", m_req, 0);
    @(negedge clk); rst = 0; d_req = 0;
    #1;
    chk("rs after m_req", m_req, 0);
    chk("rs after d_done", d_done, 0);
    chk("rs after m_addr", m_addr, 0);
    @(negedge clk); m_done = 1; m_rdata = 64'h7777;
    #1;
    @(negedge clk); m_done = 0;
    #1;
    chk("rs stray d_done", d_done, 0);
    chk("rs stray m_req", m_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
